// File: rtl/noc_arb_pkg.sv
// Shared types and the round-robin pick function for the channel arbiter.
package noc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    OREQ  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;

  // First set bit of req_vec searching upward from (last+1) mod n_req; returns last if none.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req_vec, input int last, input int n_req);
    int   pick;
    int   idx;
    logic found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (last + k) % n_req;
      if (!found && (k <= n_req) && req_vec[idx[IDX_W-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_channel_arbiter_if.sv
// Producer-side and consumer-side handshake bundle of the round-robin channel arbiter.
interface rr_channel_arbiter_if #(
  parameter int WIDTH = 7,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
);
  import noc_arb_pkg::*;

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       in_req;
  logic [N_REQ*WIDTH-1:0] in_data;
  logic [N_REQ-1:0]       in_ack;
  logic                   out_req;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ack;
  logic [GW-1:0]          grant_id;
  logic                   busy;
  logic [CNT_W-1:0]       xfer_cnt;

  modport master (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data, grant_id, busy, xfer_cnt
  );

  modport slave (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data, grant_id, busy, xfer_cnt
  );

endinterface

// File: rtl/rr_channel_arbiter_chk.sv
// Invariants tying the arbiter's registered outputs to its FSM state.
module rr_channel_arbiter_chk
  import noc_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input logic             clk,
  input logic             rst_n,
  input arb_state_t       state,
  input logic [N_REQ-1:0] in_ack,
  input logic             out_req,
  input logic             busy
);

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ack))
    else $error("in_ack not one-hot-or-zero: %b", in_ack);

  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n) busy == (state != IDLE))
    else $error("busy disagrees with state %0d", state);

  a_oreq_state: assert property (@(posedge clk) disable iff (!rst_n) out_req == (state == OREQ))
    else $error("out_req disagrees with state %0d", state);

  a_ack_state: assert property (@(posedge clk) disable iff (!rst_n) (|in_ack) == (state == DRAIN))
    else $error("in_ack disagrees with state %0d", state);

endmodule

// File: rtl/rr_channel_arbiter_sync_ff.sv
// One-bit multi-flop synchronizer for an asynchronous handshake input.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the async input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter sharing one 4-phase bundled-data channel between N_REQ producers,
// with one transfer in flight at a time and a completed-transfer counter.
module rr_channel_arbiter
  import noc_arb_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input logic                clk,
  input logic                rst_n,
  rr_channel_arbiter_if.master bus
);

  localparam int            GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);

  logic [N_REQ-1:0] in_req_s;
  logic             out_ack_s;
  logic [GW-1:0]    pick_s;
  logic [WIDTH-1:0] sel_data_s;

  arb_state_t       state_r;
  logic [GW-1:0]    grant_r;
  logic [GW-1:0]    last_grant_r;
  logic [N_REQ-1:0] in_ack_r;
  logic             out_req_r;
  logic             busy_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CNT_W-1:0] xfer_cnt_r;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.in_req[i]),
      .q     (in_req_s[i])
    );
  end

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.out_ack),
    .q     (out_ack_s)
  );

  // Next grant candidate and its bundled data slice.
  always_comb begin
    pick_s     = GW'(rr_pick(MAX_REQ'(in_req_s), int'(last_grant_r), N_REQ));
    sel_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data_s = sel_data_s | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{pick_s == GW'(i)}});
    end
  end

  // Transfer FSM with all channel outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_grant_r <= LAST_IDX;
      in_ack_r     <= '0;
      out_req_r    <= 1'b0;
      busy_r       <= 1'b0;
      out_data_r   <= '0;
      xfer_cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|in_req_s) begin
            grant_r    <= pick_s;
            out_data_r <= sel_data_s;
            busy_r     <= 1'b1;
            state_r    <= LOAD;
          end
        end
        // out_data has been stable for this whole cycle before out_req rises.
        LOAD: begin
          out_req_r <= 1'b1;
          state_r   <= OREQ;
        end
        OREQ: begin
          if (out_ack_s) begin
            out_req_r <= 1'b0;
            in_ack_r  <= N_REQ'(1'b1) << grant_r;
            state_r   <= DRAIN;
          end
        end
        // Committed grant: wait for both partners to return to zero, even if the producer left early.
        DRAIN: begin
          if (!out_ack_s && !in_req_s[grant_r]) begin
            in_ack_r     <= '0;
            last_grant_r <= grant_r;
            xfer_cnt_r   <= xfer_cnt_r + CNT_W'(1'b1);
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          in_ack_r  <= '0;
          out_req_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ack   = in_ack_r;
  assign bus.out_req  = out_req_r;
  assign bus.out_data = out_data_r;
  assign bus.grant_id = grant_r;
  assign bus.busy     = busy_r;
  assign bus.xfer_cnt = xfer_cnt_r;

  rr_channel_arbiter_chk #(.N_REQ(N_REQ)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .state   (state_r),
    .in_ack  (in_ack_r),
    .out_req (out_req_r),
    .busy    (busy_r)
  );

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed self-checking bench for rr_channel_arbiter (4 producers, 4-bit counter).
module tb_rr_channel_arbiter;

  logic clk;
  logic rst_n;

  rr_channel_arbiter_if #(.WIDTH(7), .N_REQ(4), .CNT_W(4)) bus ();

  rr_channel_arbiter #(.WIDTH(7), .N_REQ(4), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       checks;
  int       failures;
  int       tokens [4];
  bit       auto_prod;
  int       overlap_cnt;
  int       idle_gaps;
  int       ack0_pulses;
  logic     prev_busy;
  logic     prev_ack0;
  logic [6:0] d;
  logic [1:0] g;
  bit       ok;
  bit       ok2;

  // One clock: land on the falling edge, update monitors and the producer model.
  task automatic tick();
    @(negedge clk);
    if ($countones(bus.in_ack) > 1) overlap_cnt++;
    if (prev_busy && !bus.busy) idle_gaps++;
    if (bus.in_ack[0] && !prev_ack0) ack0_pulses++;
    prev_busy = bus.busy;
    prev_ack0 = bus.in_ack[0];
    if (auto_prod) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.in_req[i] && bus.in_ack[i]) begin
          bus.in_req[i] = 1'b0;
          tokens[i]--;
        end else if (!bus.in_req[i] && !bus.in_ack[i] && tokens[i] > 0) begin
          bus.in_req[i] = 1'b1;
        end
      end
    end
  endtask

  // Consumer side of one transfer; ok drops if any bounded wait expires.
  task automatic serve(input int ack_delay, output logic [6:0] data, output logic [1:0] gid,
                       output bit okay);
    int n;
    okay = 1'b1;
    n = 0;
    while (!bus.out_req && n < 100) begin tick(); n++; end
    if (!bus.out_req) okay = 1'b0;
    data = bus.out_data;
    gid  = bus.grant_id;
    repeat (ack_delay) tick();
    bus.out_ack = 1'b1;
    n = 0;
    while (bus.out_req && n < 100) begin tick(); n++; end
    if (bus.out_req) okay = 1'b0;
    bus.out_ack = 1'b0;
  endtask

  task automatic wait_idle(output bit okay);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin tick(); n++; end
    okay = !bus.busy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    auto_prod = 1'b0;
    for (int i = 0; i < 4; i++) tokens[i] = 0;
    bus.in_req  = 4'b0000;
    bus.in_data = 28'h0;
    bus.out_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++; if (bus.out_req !== 1'b0) begin failures++; $display("FAIL rst_out_req got=%b exp=0", bus.out_req); end
    checks++; if (bus.in_ack !== 4'b0000) begin failures++; $display("FAIL rst_in_ack got=%b exp=0000", bus.in_ack); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.out_data !== 7'h00) begin failures++; $display("FAIL rst_out_data got=%h exp=00", bus.out_data); end
    checks++; if (bus.xfer_cnt !== 4'h0) begin failures++; $display("FAIL rst_xfer_cnt got=%0d exp=0", bus.xfer_cnt); end
    bus.in_data[2*7 +: 7] = 7'h2C;
    bus.in_req[2] = 1'b1;
    n = 0;
    while (!bus.out_req && n < 50) begin tick(); n++; end
    checks++; if (bus.out_req !== 1'b1) begin failures++; $display("FAIL rst_reach_oreq got=%b exp=1", bus.out_req); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_req !== 1'b0) begin failures++; $display("FAIL midrst_out_req got=%b exp=0", bus.out_req); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL midrst_grant got=%0d exp=0", bus.grant_id); end
    checks++; if (bus.in_ack !== 4'b0000) begin failures++; $display("FAIL midrst_in_ack got=%b exp=0000", bus.in_ack); end
    bus.in_req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_data[2*7 +: 7] = 7'h33;
    tokens[2] = 1;
    auto_prod = 1'b1;
    serve(2, d, g, ok);
    wait_idle(ok2);
    auto_prod = 1'b0;
    checks++; if ((ok && ok2) !== 1'b1) begin failures++; $display("FAIL postrst_timeout got=%b exp=1", ok && ok2); end
    checks++; if (d !== 7'h33) begin failures++; $display("FAIL postrst_data got=%h exp=33", d); end
    checks++; if (g !== 2'd2) begin failures++; $display("FAIL postrst_grant got=%0d exp=2", g); end
    checks++; if (bus.xfer_cnt !== 4'd1) begin failures++; $display("FAIL postrst_cnt got=%0d exp=1", bus.xfer_cnt); end
  endtask

  task automatic test_single();
    tick();
    bus.in_data[1*7 +: 7] = 7'h5A;
    bus.in_req[1] = 1'b1;
    tick(); tick();
    checks++; if (bus.out_data !== 7'h33) begin failures++; $display("FAIL single_data_early got=%h exp=33", bus.out_data); end
    tick();
    checks++; if (bus.out_data !== 7'h5A) begin failures++; $display("FAIL single_data got=%h exp=5a", bus.out_data); end
    checks++; if (bus.out_req !== 1'b0) begin failures++; $display("FAIL single_req_early got=%b exp=0", bus.out_req); end
    checks++; if (bus.grant_id !== 2'd1) begin failures++; $display("FAIL single_grant got=%0d exp=1", bus.grant_id); end
    tick();
    checks++; if (bus.out_req !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", bus.out_req); end
    tick(); tick(); tick();
    checks++; if (bus.in_ack !== 4'b0000) begin failures++; $display("FAIL single_ack_noack got=%b exp=0000", bus.in_ack); end
    bus.out_ack = 1'b1;
    tick(); tick();
    checks++; if (bus.in_ack !== 4'b0000) begin failures++; $display("FAIL single_ack_sync got=%b exp=0000", bus.in_ack); end
    tick();
    checks++; if (bus.in_ack !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", bus.in_ack); end
    checks++; if (bus.out_req !== 1'b0) begin failures++; $display("FAIL single_req_fall got=%b exp=0", bus.out_req); end
    bus.in_req[1] = 1'b0;
    bus.out_ack = 1'b0;
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_idle_timeout got=%b exp=1", ok); end
    checks++; if (bus.in_ack !== 4'b0000) begin failures++; $display("FAIL single_ack_clear got=%b exp=0000", bus.in_ack); end
    checks++; if (bus.xfer_cnt !== 4'd2) begin failures++; $display("FAIL single_cnt got=%0d exp=2", bus.xfer_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.in_data[i*7 +: 7] = 7'(i);
      tokens[i] = 2;
    end
    overlap_cnt = 0;
    auto_prod = 1'b1;
    for (int k = 0; k < 8; k++) begin
      serve(1, d, g, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rr_timeout[%0d] got=%b exp=1", k, ok); end
      checks++; if (g !== 2'(k % 4)) begin failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, g, k % 4); end
      checks++; if (d !== 7'(k % 4)) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, d, k % 4); end
    end
    wait_idle(ok);
    auto_prod = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rr_idle_timeout got=%b exp=1", ok); end
    checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL rr_ack_overlap got=%0d exp=0", overlap_cnt); end
    checks++; if (bus.xfer_cnt !== 4'd8) begin failures++; $display("FAIL rr_cnt got=%0d exp=8", bus.xfer_cnt); end
  endtask

  task automatic test_back_to_back();
    bus.in_data[3*7 +: 7] = 7'h63;
    tokens[3] = 5;
    idle_gaps = 0;
    prev_busy = bus.busy;
    auto_prod = 1'b1;
    for (int k = 0; k < 5; k++) begin
      serve(0, d, g, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_timeout[%0d] got=%b exp=1", k, ok); end
      checks++; if (g !== 2'd3) begin failures++; $display("FAIL b2b_grant[%0d] got=%0d exp=3", k, g); end
      checks++; if (d !== 7'h63) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=63", k, d); end
    end
    wait_idle(ok);
    auto_prod = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_idle_timeout got=%b exp=1", ok); end
    checks++; if (idle_gaps !== 5) begin failures++; $display("FAIL b2b_idle_gaps got=%0d exp=5", idle_gaps); end
    checks++; if (bus.grant_id !== 2'd3) begin failures++; $display("FAIL b2b_grant_hold got=%0d exp=3", bus.grant_id); end
    checks++; if (bus.xfer_cnt !== 4'd13) begin failures++; $display("FAIL b2b_cnt got=%0d exp=13", bus.xfer_cnt); end
  endtask

  task automatic test_early_drop();
    int n;
    tick();
    bus.in_data[0 +: 7] = 7'h11;
    bus.in_req[0] = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL drop_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL drop_grant got=%0d exp=0", bus.grant_id); end
    ack0_pulses = 0;
    bus.in_req[0] = 1'b0;
    tick();
    checks++; if (bus.out_req !== 1'b1) begin failures++; $display("FAIL drop_out_req got=%b exp=1", bus.out_req); end
    checks++; if (bus.out_data !== 7'h11) begin failures++; $display("FAIL drop_data got=%h exp=11", bus.out_data); end
    bus.out_ack = 1'b1;
    n = 0;
    while (bus.out_req && n < 50) begin tick(); n++; end
    bus.out_ack = 1'b0;
    wait_idle(ok);
    checks++; if ((ok && !bus.out_req) !== 1'b1) begin failures++; $display("FAIL drop_timeout got=%b exp=1", ok && !bus.out_req); end
    checks++; if (ack0_pulses !== 1) begin failures++; $display("FAIL drop_ack_pulses got=%0d exp=1", ack0_pulses); end
    checks++; if (bus.xfer_cnt !== 4'd14) begin failures++; $display("FAIL drop_cnt got=%0d exp=14", bus.xfer_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.in_data[1*7 +: 7] = 7'h4B;
    tokens[1] = 17;
    auto_prod = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      serve(0, d, g, ok);
      wait_idle(ok2);
      checks++; if ((ok && ok2) !== 1'b1) begin failures++; $display("FAIL wrap_timeout[%0d] got=%b exp=1", k, ok && ok2); end
      checks++; if (d !== 7'h4B) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=4b", k, d); end
      checks++; if (bus.xfer_cnt !== 4'(k)) begin failures++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", k, bus.xfer_cnt, k % 16); end
    end
    auto_prod = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_busy = 1'b0;
    prev_ack0 = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_early_drop();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
